// File: rtl/usb_packet_parser_if.sv
// Handshake and status bundle between the USB word stream and the packet parser.
interface usb_packet_parser_if #(
  parameter int LEN_WIDTH = 10
);
  logic [15:0]          in_data;
  logic                 in_valid;
  logic                 in_ready;
  logic [15:0]          out_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [3:0]           out_dest;
  logic                 out_last;
  logic                 cmd_valid;
  logic [3:0]           cmd_dest;
  logic [3:0]           cmd_code;
  logic [LEN_WIDTH-1:0] cmd_len;
  logic                 pkt_ok;
  logic [7:0]           err_count;
  logic                 hunting;

  // Stream source / result consumer side
  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_dest, out_last,
    input  cmd_valid, cmd_dest, cmd_code, cmd_len, pkt_ok, err_count, hunting
  );

  // Parser side
  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_dest, out_last,
    output cmd_valid, cmd_dest, cmd_code, cmd_len, pkt_ok, err_count, hunting
  );
endinterface

// File: rtl/usb_packet_parser.sv
// Frames the host word stream into header/length/payload/checksum packets,
// forwards payload words per slot and reports a per-packet verdict.
module usb_packet_parser #(
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter int         LEN_WIDTH = 10,
  parameter int         MAX_LEN   = 512
) (
  input logic ifclk,
  input logic reset,
  usb_packet_parser_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_LEN, S_PAYLOAD, S_CKSUM} state_t;

  localparam logic [15:0]          MAX_LEN_W = 16'(MAX_LEN);
  localparam logic [LEN_WIDTH-1:0] ONE       = LEN_WIDTH'(1);

  state_t               state;
  logic [15:0]          sum;
  logic [LEN_WIDTH-1:0] remaining;
  logic [LEN_WIDTH-1:0] len;
  logic [3:0]           dest;
  logic [3:0]           code;
  logic                 accept;
  logic [15:0]          w;

  assign w       = bus.in_data;
  assign accept  = bus.in_valid && bus.in_ready;
  assign bus.hunting = (state == S_IDLE);

  // Only the payload stage can stall: it needs the output register free (or draining).
  always_comb begin
    bus.in_ready = 1'b0;
    if (!reset) begin
      if (state == S_PAYLOAD) bus.in_ready = !bus.out_valid || bus.out_ready;
      else                    bus.in_ready = 1'b1;
    end
  end

  // Packet framing FSM with registered payload and verdict outputs.
  always_ff @(posedge ifclk) begin
    if (reset) begin
      state         <= S_IDLE;
      sum           <= '0;
      remaining     <= '0;
      len           <= '0;
      dest          <= '0;
      code          <= '0;
      bus.out_data  <= '0;
      bus.out_valid <= 1'b0;
      bus.out_dest  <= '0;
      bus.out_last  <= 1'b0;
      bus.cmd_valid <= 1'b0;
      bus.cmd_dest  <= '0;
      bus.cmd_code  <= '0;
      bus.cmd_len   <= '0;
      bus.pkt_ok    <= 1'b0;
      bus.err_count <= '0;
    end else begin
      bus.cmd_valid <= 1'b0;
      // Held word leaves on handshake; a same-cycle payload accept re-fills below.
      if (bus.out_valid && bus.out_ready) bus.out_valid <= 1'b0;

      if (accept) begin
        case (state)
          S_IDLE: begin
            if (w[15:8] == SYNC_BYTE) begin
              dest  <= w[7:4];
              code  <= w[3:0];
              sum   <= w;
              state <= S_LEN;
            end
          end
          S_LEN: begin
            sum <= sum + w;
            len <= w[LEN_WIDTH-1:0];
            // Full-width compare so stray high bits also count as a length error.
            if (w > MAX_LEN_W) begin
              bus.cmd_valid <= 1'b1;
              bus.cmd_dest  <= dest;
              bus.cmd_code  <= code;
              bus.cmd_len   <= w[LEN_WIDTH-1:0];
              bus.pkt_ok    <= 1'b0;
              if (bus.err_count != 8'hFF) bus.err_count <= bus.err_count + 8'd1;
              state <= S_IDLE;
            end else if (w[LEN_WIDTH-1:0] == '0) begin
              state <= S_CKSUM;
            end else begin
              remaining <= w[LEN_WIDTH-1:0];
              state     <= S_PAYLOAD;
            end
          end
          S_PAYLOAD: begin
            sum           <= sum + w;
            bus.out_data  <= w;
            bus.out_valid <= 1'b1;
            bus.out_dest  <= dest;
            bus.out_last  <= (remaining == ONE);
            remaining     <= remaining - ONE;
            if (remaining == ONE) state <= S_CKSUM;
          end
          S_CKSUM: begin
            bus.cmd_valid <= 1'b1;
            bus.cmd_dest  <= dest;
            bus.cmd_code  <= code;
            bus.cmd_len   <= len;
            bus.pkt_ok    <= (w == sum);
            if (w != sum && bus.err_count != 8'hFF) bus.err_count <= bus.err_count + 8'd1;
            state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_usb_packet_parser.sv
// Self-checking bench for usb_packet_parser against a packet-level reference model.
module tb_usb_packet_parser;
  localparam int LW   = 10;
  localparam int MAXL = 512;

  logic ifclk = 1'b0;
  logic reset;
  always #5 ifclk = ~ifclk;

  usb_packet_parser_if #(.LEN_WIDTH(LW)) bus();

  usb_packet_parser #(.SYNC_BYTE(8'hA5), .LEN_WIDTH(LW), .MAX_LEN(MAXL)) dut (
    .ifclk(ifclk),
    .reset(reset),
    .bus  (bus.slave)
  );

  int tests = 0;
  int failed = 0;
  int exp_err = 0;
  int rdy_mode = 0;   // 0: always ready, 1: random, 2: stalled
  bit gaps = 0;

  logic [15:0] stim[$];
  logic [20:0] exp_out[$], obs_out[$];   // {last, dest, data}
  logic [18:0] exp_cmd[$], obs_cmd[$];   // {dest, code, len, ok}

  // Downstream ready pattern
  always @(posedge ifclk) begin
    #1;
    if (rdy_mode == 0)      bus.out_ready = 1'b1;
    else if (rdy_mode == 1) bus.out_ready = ($urandom_range(0, 3) != 0);
    else                    bus.out_ready = 1'b0;
  end

  // Record output handshakes and verdict pulses
  always @(negedge ifclk) begin
    if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1)
      obs_out.push_back({bus.out_last, bus.out_dest, bus.out_data});
    if (bus.cmd_valid === 1'b1)
      obs_cmd.push_back({bus.cmd_dest, bus.cmd_code, bus.cmd_len, bus.pkt_ok});
  end

  // Packet-level reference: scan for sync, read length, slice payload, sum words.
  task automatic model();
    int i = 0;
    int n = stim.size();
    logic [15:0] h, l, s;
    while (i < n) begin
      h = stim[i]; i++;
      if (h[15:8] != 8'hA5 || i >= n) continue;
      l = stim[i]; i++;
      s = h + l;
      if (int'(l) > MAXL) begin
        exp_cmd.push_back({h[7:4], h[3:0], l[LW-1:0], 1'b0});
        if (exp_err < 255) exp_err++;
        continue;
      end
      for (int k = 0; k < int'(l); k++) begin
        s = s + stim[i];
        exp_out.push_back({(k == int'(l) - 1), h[7:4], stim[i]});
        i++;
      end
      exp_cmd.push_back({h[7:4], h[3:0], l[LW-1:0], (stim[i] == s)});
      if (stim[i] != s && exp_err < 255) exp_err++;
      i++;
    end
  endtask

  task automatic drive();
    foreach (stim[j]) begin
      int t = 0;
      bus.in_data  = stim[j];
      bus.in_valid = 1'b1;
      do begin @(negedge ifclk); t++; end while (bus.in_ready !== 1'b1 && t < 500);
      if (bus.in_ready !== 1'b1) begin
        tests++; failed++;
        $display("FAIL accept_timeout word %0d in_ready=%b required 1", j, bus.in_ready);
      end
      @(posedge ifclk); #1;
      bus.in_valid = 1'b0;
      if (gaps && $urandom_range(0, 3) == 0) begin @(posedge ifclk); #1; end
    end
  endtask

  task automatic run();
    exp_out.delete(); exp_cmd.delete();
    obs_out.delete(); obs_cmd.delete();
    model();
    drive();
    repeat (40) @(posedge ifclk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    repeat (2) @(posedge ifclk);
    @(negedge ifclk);
    tests++; if (bus.in_ready !== 1'b0) begin failed++; $display("FAIL rst_in_ready got %b want 0", bus.in_ready); end
    tests++; if (bus.out_valid !== 1'b0 || bus.out_last !== 1'b0 || bus.out_data !== 16'h0 || bus.out_dest !== 4'h0) begin
      failed++; $display("FAIL rst_out got v=%b l=%b d=%h s=%h want all 0", bus.out_valid, bus.out_last, bus.out_data, bus.out_dest); end
    tests++; if (bus.cmd_valid !== 1'b0 || bus.cmd_dest !== 4'h0 || bus.cmd_code !== 4'h0 || bus.cmd_len !== '0 || bus.pkt_ok !== 1'b0) begin
      failed++; $display("FAIL rst_cmd got v=%b d=%h c=%h l=%h ok=%b want all 0", bus.cmd_valid, bus.cmd_dest, bus.cmd_code, bus.cmd_len, bus.pkt_ok); end
    tests++; if (bus.err_count !== 8'h00 || bus.hunting !== 1'b1) begin
      failed++; $display("FAIL rst_status got err=%h hunt=%b want 00/1", bus.err_count, bus.hunting); end
    @(posedge ifclk); #1;
    reset = 1'b0;
    @(negedge ifclk);
    tests++; if (bus.in_ready !== 1'b1) begin failed++; $display("FAIL post_rst_in_ready got %b want 1", bus.in_ready); end
    @(posedge ifclk); #1;
    exp_err = 0;
  endtask

  task automatic test_basic();
    stim = '{16'hA523, 16'h0002, 16'h1111, 16'h2222, 16'hD858};
    rdy_mode = 0; gaps = 0;
    fork
      run();
      begin
        int t = 0;
        do begin @(negedge ifclk); t++; end
          while (!(bus.in_valid && bus.in_ready && bus.in_data == 16'h1111) && t < 200);
        @(negedge ifclk);
        tests++; if (bus.out_valid !== 1'b1 || bus.out_data !== 16'h1111) begin
          failed++; $display("FAIL out_latency got v=%b d=%h want 1/1111", bus.out_valid, bus.out_data); end
        t = 0;
        do begin @(negedge ifclk); t++; end
          while (!(bus.in_valid && bus.in_ready && bus.in_data == 16'hD858) && t < 200);
        @(negedge ifclk);
        tests++; if (bus.cmd_valid !== 1'b1) begin failed++; $display("FAIL cmd_latency got %b want 1", bus.cmd_valid); end
        @(negedge ifclk);
        tests++; if (bus.cmd_valid !== 1'b0) begin failed++; $display("FAIL cmd_pulse_width got %b want 0", bus.cmd_valid); end
      end
    join
    tests++; if (obs_out.size() != exp_out.size()) begin failed++; $display("FAIL basic_out_count got %0d want %0d", obs_out.size(), exp_out.size()); end
    for (int j = 0; j < exp_out.size() && j < obs_out.size(); j++) begin
      tests++; if (obs_out[j] !== exp_out[j]) begin failed++; $display("FAIL basic_out[%0d] got %h want %h", j, obs_out[j], exp_out[j]); end
    end
    tests++; if (obs_cmd.size() != 1 || obs_cmd[0] !== {4'h2, 4'h3, 10'd2, 1'b1}) begin
      failed++; $display("FAIL basic_cmd got n=%0d %h want n=1 %h", obs_cmd.size(), obs_cmd[0], {4'h2, 4'h3, 10'd2, 1'b1}); end
    tests++; if (bus.err_count !== 8'(exp_err)) begin failed++; $display("FAIL basic_err got %h want %h", bus.err_count, 8'(exp_err)); end
  endtask

  task automatic test_bad_cksum();
    stim = '{16'hA523, 16'h0002, 16'h1111, 16'h2222, 16'hD859};
    run();
    tests++; if (obs_out.size() != exp_out.size()) begin failed++; $display("FAIL badck_out_count got %0d want %0d", obs_out.size(), exp_out.size()); end
    for (int j = 0; j < exp_out.size() && j < obs_out.size(); j++) begin
      tests++; if (obs_out[j] !== exp_out[j]) begin failed++; $display("FAIL badck_out[%0d] got %h want %h", j, obs_out[j], exp_out[j]); end
    end
    tests++; if (obs_cmd.size() != 1 || obs_cmd[0] !== exp_cmd[0]) begin
      failed++; $display("FAIL badck_cmd got n=%0d %h want %h", obs_cmd.size(), obs_cmd[0], exp_cmd[0]); end
    tests++; if (bus.err_count !== 8'h01) begin failed++; $display("FAIL badck_err got %h want 01", bus.err_count); end
  endtask

  task automatic test_zero_len();
    stim = '{16'hA510, 16'h0000, 16'hA510};
    run();
    tests++; if (obs_out.size() != 0) begin failed++; $display("FAIL zlen_out_count got %0d want 0", obs_out.size()); end
    tests++; if (obs_cmd.size() != 1 || obs_cmd[0] !== {4'h1, 4'h0, 10'd0, 1'b1}) begin
      failed++; $display("FAIL zlen_cmd got n=%0d %h want %h", obs_cmd.size(), obs_cmd[0], {4'h1, 4'h0, 10'd0, 1'b1}); end
  endtask

  task automatic test_wrap_garbage();
    stim = '{16'h1234, 16'h00FF, 16'hA5F0, 16'h0001, 16'hFFFF, 16'hA5F0};
    fork
      run();
      repeat (12) begin
        @(negedge ifclk);
        if (bus.in_valid && bus.in_ready && (bus.in_data == 16'h1234 || bus.in_data == 16'h00FF)) begin
          tests++; if (bus.hunting !== 1'b1) begin failed++; $display("FAIL garbage_hunting got %b want 1", bus.hunting); end
        end
      end
    join
    tests++; if (obs_out.size() != 1 || obs_out[0] !== {1'b1, 4'hF, 16'hFFFF}) begin
      failed++; $display("FAIL wrap_out got n=%0d %h want %h", obs_out.size(), obs_out[0], {1'b1, 4'hF, 16'hFFFF}); end
    tests++; if (obs_cmd.size() != 1 || obs_cmd[0] !== exp_cmd[0] || obs_cmd[0][0] !== 1'b1) begin
      failed++; $display("FAIL wrap_cmd got n=%0d %h want %h", obs_cmd.size(), obs_cmd[0], exp_cmd[0]); end
  endtask

  task automatic test_backpressure();
    stim = '{16'hA523, 16'h0002, 16'h1111, 16'h2222, 16'hD858, 16'hA500, 16'h0201};
    rdy_mode = 2;
    @(posedge ifclk); #1;
    fork
      run();
      begin
        int t = 0;
        do begin @(negedge ifclk); t++; end while (bus.out_valid !== 1'b1 && t < 200);
        repeat (5) begin
          tests++; if (bus.out_data !== 16'h1111 || bus.out_valid !== 1'b1) begin
            failed++; $display("FAIL bp_hold got v=%b d=%h want 1/1111", bus.out_valid, bus.out_data); end
          tests++; if (bus.in_ready !== 1'b0) begin failed++; $display("FAIL bp_in_ready got %b want 0", bus.in_ready); end
          @(negedge ifclk);
        end
        rdy_mode = 0;
      end
    join
    tests++; if (obs_out.size() != exp_out.size()) begin failed++; $display("FAIL bp_out_count got %0d want %0d", obs_out.size(), exp_out.size()); end
    for (int j = 0; j < exp_out.size() && j < obs_out.size(); j++) begin
      tests++; if (obs_out[j] !== exp_out[j]) begin failed++; $display("FAIL bp_out[%0d] got %h want %h", j, obs_out[j], exp_out[j]); end
    end
    tests++; if (obs_cmd.size() != 2) begin failed++; $display("FAIL bp_cmd_count got %0d want 2", obs_cmd.size()); end
    for (int j = 0; j < exp_cmd.size() && j < obs_cmd.size(); j++) begin
      tests++; if (obs_cmd[j] !== exp_cmd[j]) begin failed++; $display("FAIL bp_cmd[%0d] got %h want %h", j, obs_cmd[j], exp_cmd[j]); end
    end
    tests++; if (bus.err_count !== 8'h02 || bus.hunting !== 1'b1) begin
      failed++; $display("FAIL lenerr_status got err=%h hunt=%b want 02/1", bus.err_count, bus.hunting); end
  endtask

  task automatic test_reset_mid();
    stim = '{16'hA523, 16'h0002, 16'h1111};
    rdy_mode = 2;
    obs_out.delete(); obs_cmd.delete();
    @(posedge ifclk); #1;
    drive();
    reset = 1'b1;
    @(posedge ifclk); #1;
    reset = 1'b0;
    exp_err = 0;
    @(negedge ifclk);
    tests++; if (bus.out_valid !== 1'b0 || bus.hunting !== 1'b1 || bus.cmd_valid !== 1'b0) begin
      failed++; $display("FAIL midrst got v=%b hunt=%b cmd=%b want 0/1/0", bus.out_valid, bus.hunting, bus.cmd_valid); end
    tests++; if (obs_cmd.size() != 0) begin failed++; $display("FAIL midrst_cmd_count got %0d want 0", obs_cmd.size()); end
    rdy_mode = 0;
    @(posedge ifclk); #1;
    stim = '{16'hA523, 16'h0002, 16'h1111, 16'h2222, 16'hD858};
    run();
    tests++; if (obs_out.size() != 2 || obs_out[0] !== exp_out[0] || obs_out[1] !== exp_out[1]) begin
      failed++; $display("FAIL midrst_out got n=%0d %h want n=2 %h", obs_out.size(), obs_out[0], exp_out[0]); end
    tests++; if (obs_cmd.size() != 1 || obs_cmd[0] !== {4'h2, 4'h3, 10'd2, 1'b1}) begin
      failed++; $display("FAIL midrst_cmd got n=%0d %h want %h", obs_cmd.size(), obs_cmd[0], {4'h2, 4'h3, 10'd2, 1'b1}); end
  endtask

  task automatic test_random();
    logic [15:0] h, s, p, g, l;
    stim.delete();
    repeat (60) begin
      if ($urandom_range(0, 4) == 0) begin
        g = 16'($urandom);
        if (g[15:8] == 8'hA5) g[15:8] = 8'h00;
        stim.push_back(g);
      end
      h = {8'hA5, 8'($urandom)};
      if ($urandom_range(0, 9) == 0) begin
        stim.push_back(h);
        stim.push_back(16'(MAXL + 1 + $urandom_range(0, 60000)));
      end else begin
        l = 16'($urandom_range(0, 7));
        s = h + l;
        stim.push_back(h);
        stim.push_back(l);
        for (int k = 0; k < int'(l); k++) begin
          p = 16'($urandom);
          s = s + p;
          stim.push_back(p);
        end
        stim.push_back(($urandom_range(0, 3) == 0) ? (s ^ 16'h0100) : s);
      end
    end
    rdy_mode = 1; gaps = 1;
    run();
    rdy_mode = 0; gaps = 0;
    tests++; if (obs_out.size() != exp_out.size()) begin failed++; $display("FAIL rnd_out_count got %0d want %0d", obs_out.size(), exp_out.size()); end
    for (int j = 0; j < exp_out.size() && j < obs_out.size(); j++) begin
      tests++; if (obs_out[j] !== exp_out[j]) begin failed++; $display("FAIL rnd_out[%0d] got %h want %h", j, obs_out[j], exp_out[j]); end
    end
    tests++; if (obs_cmd.size() != exp_cmd.size()) begin failed++; $display("FAIL rnd_cmd_count got %0d want %0d", obs_cmd.size(), exp_cmd.size()); end
    for (int j = 0; j < exp_cmd.size() && j < obs_cmd.size(); j++) begin
      tests++; if (obs_cmd[j] !== exp_cmd[j]) begin failed++; $display("FAIL rnd_cmd[%0d] got %h want %h", j, obs_cmd[j], exp_cmd[j]); end
    end
    tests++; if (bus.err_count !== 8'(exp_err)) begin failed++; $display("FAIL rnd_err got %h want %h", bus.err_count, 8'(exp_err)); end
  endtask

  task automatic test_saturation();
    logic [15:0] h;
    stim.delete();
    repeat (300) begin
      h = {8'hA5, 8'($urandom)};
      stim.push_back(h);
      stim.push_back(16'h0000);
      stim.push_back(h ^ 16'h0001);
    end
    run();
    tests++; if (obs_cmd.size() != 300) begin failed++; $display("FAIL sat_cmd_count got %0d want 300", obs_cmd.size()); end
    for (int j = 0; j < exp_cmd.size() && j < obs_cmd.size(); j++) begin
      tests++; if (obs_cmd[j] !== exp_cmd[j]) begin failed++; $display("FAIL sat_cmd[%0d] got %h want %h", j, obs_cmd[j], exp_cmd[j]); end
    end
    tests++; if (bus.err_count !== 8'hFF) begin failed++; $display("FAIL sat_err got %h want FF", bus.err_count); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bad_cksum();
    test_zero_len();
    test_wrap_garbage();
    test_backpressure();
    test_reset_mid();
    test_random();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
